// File: rtl/deser8_collector.sv
`default_nettype none
// ============================================================================
// Module   : deser8_collector
// Brief    : Bit-serial to parallel collector with valid/ready word output and
//            registered all-ones / all-zeros flags.
// Revision : 1.0
// ============================================================================
module deser8_collector #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             all_ones,
    output logic             all_zeros,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] w_word_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ones;
    logic             r_zeros;
    logic             w_accept;
    logic             w_last;

    assign w_accept = bit_valid && (r_state == S_COLLECT);
    assign w_last   = w_accept && (r_cnt == c_last);

    // LSB-first writes the bit at its final index; MSB-first shifts left so
    // the first bit received ends up in the top position.
    generate
        if (LSB_FIRST != 0) begin : g_lsb
            for (genvar k = 0; k < WIDTH; k++) begin : g_bit
                assign w_word_nxt[k] = (r_cnt == CNT_W'(k)) ? bit_in : r_word[k];
            end
        end else begin : g_msb
            assign w_word_nxt = {r_word[WIDTH-2:0], bit_in};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_COLLECT;
        end else begin
            case (r_state)
                S_COLLECT: if (w_last)     w_state_nxt = S_HOLD;
                S_HOLD:    if (word_ready) w_state_nxt = S_COLLECT;
                default:                   w_state_nxt = S_COLLECT;
            endcase
        end
    end

    // Flags only refresh on word completion so they stay tied to the held word.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_word  <= '0;
            r_cnt   <= '0;
            r_ones  <= 1'b0;
            r_zeros <= 1'b0;
        end else begin
            if (w_accept) begin
                r_word <= w_word_nxt;
                r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
            if (w_last) begin
                r_ones  <= &w_word_nxt;
                r_zeros <= ~|w_word_nxt;
            end
        end
    end

    assign bit_ready  = (r_state == S_COLLECT);
    assign word_valid = (r_state == S_HOLD);
    assign word_out   = r_word;
    assign all_ones   = r_ones;
    assign all_zeros  = r_zeros;
    assign bit_count  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_deser8_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_deser8_collector
// Brief    : Directed scoreboard bench; runs an LSB-first and an MSB-first
//            collector side by side on the same serial stream.
// Revision : 1.0
// ============================================================================
module tb_deser8_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       word_ready = 1'b0;

    logic       l_bit_ready, l_word_valid, l_all_ones, l_all_zeros;
    logic [7:0] l_word_out;
    logic [2:0] l_bit_count;
    logic       m_bit_ready, m_word_valid, m_all_ones, m_all_zeros;
    logic [7:0] m_word_out;
    logic [2:0] m_bit_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] q_lsb[$];
    logic [7:0] q_msb[$];

    deser8_collector #(.WIDTH(8), .LSB_FIRST(1), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(l_bit_ready), .word_out(l_word_out), .word_valid(l_word_valid),
        .word_ready(word_ready), .all_ones(l_all_ones), .all_zeros(l_all_zeros),
        .bit_count(l_bit_count)
    );

    deser8_collector #(.WIDTH(8), .LSB_FIRST(0), .CNT_W(3)) dut_m (
        .clk(clk), .rst(rst), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(m_bit_ready), .word_out(m_word_out), .word_valid(m_word_valid),
        .word_ready(word_ready), .all_ones(m_all_ones), .all_zeros(m_all_zeros),
        .bit_count(m_bit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Sends the first n bits of w, w[0] first; a full word goes to the scoreboard.
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            bit_in    = w[i];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        if (n == 8) begin
            q_lsb.push_back(w);
            q_msb.push_back(rev8(w));
        end
    endtask

    task automatic check_word(input string tag);
        logic [7:0] el, em;
        chk({tag, ".l_valid"}, 32'(l_word_valid), 32'd1);
        chk({tag, ".m_valid"}, 32'(m_word_valid), 32'd1);
        chk({tag, ".l_ready"}, 32'(l_bit_ready), 32'd0);
        chk({tag, ".m_ready"}, 32'(m_bit_ready), 32'd0);
        chk({tag, ".l_cnt"}, 32'(l_bit_count), 32'd0);
        chk({tag, ".q_size"}, 32'(q_lsb.size() > 0 && q_msb.size() > 0), 32'd1);
        if (q_lsb.size() > 0 && q_msb.size() > 0) begin
            el = q_lsb.pop_front();
            em = q_msb.pop_front();
            chk({tag, ".l_word"}, 32'(l_word_out), 32'(el));
            chk({tag, ".l_ones"}, 32'(l_all_ones), 32'(&el));
            chk({tag, ".l_zeros"}, 32'(l_all_zeros), 32'(~|el));
            chk({tag, ".m_word"}, 32'(m_word_out), 32'(em));
            chk({tag, ".m_ones"}, 32'(m_all_ones), 32'(&em));
            chk({tag, ".m_zeros"}, 32'(m_all_zeros), 32'(~|em));
        end
    endtask

    task automatic handshake(input string tag);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk({tag, ".hs_l_valid"}, 32'(l_word_valid), 32'd0);
        chk({tag, ".hs_m_valid"}, 32'(m_word_valid), 32'd0);
        chk({tag, ".hs_l_ready"}, 32'(l_bit_ready), 32'd1);
        chk({tag, ".hs_m_ready"}, 32'(m_bit_ready), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".l_valid"}, 32'(l_word_valid), 32'd0);
        chk({tag, ".l_ready"}, 32'(l_bit_ready), 32'd1);
        chk({tag, ".l_word"}, 32'(l_word_out), 32'd0);
        chk({tag, ".l_ones"}, 32'(l_all_ones), 32'd0);
        chk({tag, ".l_zeros"}, 32'(l_all_zeros), 32'd0);
        chk({tag, ".l_cnt"}, 32'(l_bit_count), 32'd0);
        chk({tag, ".m_valid"}, 32'(m_word_valid), 32'd0);
        chk({tag, ".m_word"}, 32'(m_word_out), 32'd0);
        chk({tag, ".m_cnt"}, 32'(m_bit_count), 32'd0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("reset");

        // 1,0,1,1,0,0,1,0 -> 0x4D, valid the cycle after the 8th bit
        send_bits(8'h4D, 8);
        check_word("w4d");
        handshake("w4d");

        // All ones, valid for exactly two cycles
        send_bits(8'hFF, 8);
        check_word("wff");
        tick();
        chk("wff.hold2_valid", 32'(l_word_valid), 32'd1);
        chk("wff.hold2_word", 32'(l_word_out), 32'hFF);
        handshake("wff");

        // All zeros, then a single leading one (0x80 on the MSB-first unit)
        send_bits(8'h00, 8);
        check_word("w00");
        handshake("w00");
        send_bits(8'h01, 8);
        check_word("w01");
        handshake("w01");

        // Partial word aborted by clear, which also beats a same-cycle bit
        send_bits(8'hFF, 5);
        chk("part.l_cnt", 32'(l_bit_count), 32'd5);
        chk("part.m_cnt", 32'(m_bit_count), 32'd5);
        clear = 1'b1;
        bit_in = 1'b1;
        bit_valid = 1'b1;
        tick();
        clear = 1'b0;
        bit_valid = 1'b0;
        check_idle("clear");
        send_bits(8'hA5, 8);
        check_word("wa5");

        // clear while holding a word discards it
        clear = 1'b1;
        word_ready = 1'b1;
        tick();
        clear = 1'b0;
        word_ready = 1'b0;
        check_idle("clear_hold");

        // Bits offered during HOLD are ignored
        send_bits(8'h3C, 8);
        check_word("w3c");
        bit_in = 1'b1;
        bit_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ign.l_word", 32'(l_word_out), 32'h3C);
            chk("ign.m_word", 32'(m_word_out), 32'(rev8(8'h3C)));
            chk("ign.l_cnt", 32'(l_bit_count), 32'd0);
            chk("ign.l_valid", 32'(l_word_valid), 32'd1);
        end
        bit_valid = 1'b0;
        handshake("w3c");
        send_bits(8'h12, 8);
        check_word("w12");
        handshake("w12");

        // Reset collides with the 8th bit, clear and word_ready
        send_bits(8'h6B, 7);
        bit_in = 1'b0;
        bit_valid = 1'b1;
        rst = 1'b1;
        clear = 1'b1;
        word_ready = 1'b1;
        tick();
        rst = 1'b0;
        clear = 1'b0;
        word_ready = 1'b0;
        bit_valid = 1'b0;
        check_idle("rst_8th");
        send_bits(8'h5A, 8);
        check_word("w5a");
        handshake("w5a");

        chk("sb.empty", 32'(q_lsb.size() + q_msb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/deser8_collector.md
Name: deser8_collector

Overview:
- Bit-serial to parallel collector: accepts one data bit per handshake and assembles WIDTH bits into a word.
- Presents the word on a valid/ready output handshake, with registered all-ones and all-zeros reduction flags.
- This is the expanding counterpart of the datapath's 8-input reduction gates: it fans a single-bit stream out into an 8-bit word.
- Used to load bytes from a serial debug/loader path into the single-cycle processor's register/memory write side.

Parameters:
WIDTH, 8, number of bits per assembled word (2..32)
LSB_FIRST, 1, 1 = first received bit lands in bit 0; 0 = first received bit lands in bit WIDTH-1
CNT_W, 3, width of bit counter; must satisfy 2^CNT_W >= WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
clear  input  1  synchronous abort; discards partial word and any held word
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in is valid this cycle
bit_ready  output  1  collector can accept a bit this cycle
word_out  output  WIDTH  assembled word
word_valid  output  1  word_out is complete and held
word_ready  input  1  consumer accepts word_out this cycle
all_ones  output  1  registered AND-reduction of word_out
all_zeros  output  1  registered NOR-reduction of word_out
bit_count  output  CNT_W  number of bits collected into current partial word

Behaviour:
- Reset: one clock, synchronous, active-high (rst). On reset:
  - state=COLLECT; word_out=0; word_valid=0; all_ones=0; all_zeros=0; bit_count=0.
  - bit_ready=1 in the first cycle after reset.
- States:
  - COLLECT: bit_ready=1, word_valid=0.
  - HOLD: bit_ready=0, word_valid=1.
- Bit acceptance: a bit is accepted on a rising edge where bit_valid && bit_ready. bit_valid with bit_ready=0 is ignored; the bit is not buffered.
- Bit placement:
  - LSB_FIRST=1: bit k of the word (k = bit_count at acceptance) = bit_in.
  - LSB_FIRST=0: the shift register shifts left and bit_in enters bit 0, so the first bit ends in bit WIDTH-1.
- Intermediate bits: on an accepted bit with bit_count < WIDTH-1, bit_count increments and state stays COLLECT. word_out is internal shift data; it is only meaningful while word_valid=1.
- Completing a word: on the accepted bit with bit_count == WIDTH-1:
  - state goes to HOLD and bit_count wraps to 0;
  - word_out, all_ones and all_zeros all update on the same edge.
  - Latency: word_valid=1 in the cycle immediately after the edge that captured the last bit.
- HOLD:
  - word_out, all_ones and all_zeros stay stable until word_ready.
  - Edge with word_ready=1: state goes to COLLECT and word_valid=0 next cycle.
  - The next bit can be accepted one cycle after the handshake; there is no bypass in the same cycle.
  - word_ready in COLLECT is ignored.
- Flags: all_ones = &word_out and all_zeros = ~|word_out, both registered with word_out. They are meaningful only while word_valid=1 and are cleared to 0 on reset/clear.
- clear:
  - Behaves like reset for state, bit_count, word_valid and the flags. word_out is zeroed.
  - Has priority over bit acceptance and word_ready in the same cycle.
  - Has no effect while rst=1; rst has top priority.
- Reset mid-word: the partial word is discarded and the next accepted bit is bit 0 of a new word.
- Throughput: maximum one word per WIDTH+1 cycles (WIDTH bit cycles plus one HOLD cycle with word_ready=1).
- Not permitted: no combinational path from bit_valid to any output, and none from word_ready to bit_ready. All outputs are register- or state-decoded.

Test Plan:
- Reset then send 1,0,1,1,0,0,1,0 (LSB_FIRST=1, bit_valid held high, word_ready=0) -> word_valid rises the cycle after the 8th bit; word_out=8'h4D, all_ones=0, all_zeros=0, bit_ready=0.
- Eight 1s, with word_ready=1 on the 2nd HOLD cycle -> word_out=8'hFF, all_ones=1, word_valid for exactly 2 cycles, bit_ready=1 the cycle after the handshake.
- Eight 0s with LSB_FIRST=0, then the sequence 1,0,0,0,0,0,0,0 -> first word 8'h00 with all_zeros=1; second word 8'h80.
- Send 5 bits, pulse clear, then send 8 bits of 8'hA5 (LSB first: 1,0,1,0,0,1,0,1) -> bit_count=0 after clear; word_out=8'hA5, and the partial bits do not appear.
- While in HOLD, drive bit_valid=1 with bit_in=1 for 3 cycles, then word_ready -> ignored bits are not captured; the next word starts from bit_count=0 and word_out is unchanged during HOLD.
- Assert rst in the same cycle as the 8th bit and as clear/word_ready -> word_valid stays 0, bit_count=0, word_out=0, bit_ready=1 in the following cycle.
